// File: rtl/yontem_pkg.sv
// rtl/yontem_pkg.sv - shared constants, stage payload and slice helper for the pipelined subtractor
package yontem_pkg;

  localparam int WIDTH_C  = 64;
  localparam int SLICE_C  = 16;
  localparam int STAGES_C = WIDTH_C / SLICE_C;

  // One pipeline rank: finished low slices in res, full skewed operands
  // (b already inverted), carry into the next slice and the operand signs.
  typedef struct packed {
    logic               valid;
    logic [WIDTH_C-1:0] res;
    logic [WIDTH_C-1:0] a;
    logic [WIDTH_C-1:0] b;
    logic               carry;
    logic               sign_a;
    logic               sign_b;
  } stage_t;

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/csel_slice.sv
// rtl/csel_slice.sv - combinational carry-select slice: two ripple sums, late carry-in mux
module csel_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_sel,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout
);

  logic [SLICE:0]   w_c0;
  logic [SLICE:0]   w_c1;
  logic [SLICE-1:0] w_s0;
  logic [SLICE-1:0] w_s1;

  always_comb begin
    w_c0    = '0;
    w_c1    = '0;
    w_s0    = '0;
    w_s1    = '0;
    w_c1[0] = 1'b1;
    for (int i = 0; i < SLICE; i++) begin
      w_s0[i]   = i_a[i] ^ i_b[i] ^ w_c0[i];
      w_c0[i+1] = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
      w_s1[i]   = i_a[i] ^ i_b[i] ^ w_c1[i];
      w_c1[i+1] = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_sum  = i_sel ? w_s1 : w_s0;
  assign o_cout = i_sel ? w_c1[SLICE] : w_c0[SLICE];

endmodule

// File: rtl/yontem4_pipelined_subtractor.sv
// rtl/yontem4_pipelined_subtractor.sv - 4-stage carry-select subtractor with valid/ready handshake
module yontem4_pipelined_subtractor
  import yontem_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int SLICE = SLICE_C
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int STAGES = WIDTH / SLICE;

  // r_stg[k] feeds the slice-k adder; the output registers form the last rank.
  stage_t           r_stg [STAGES];
  stage_t           w_nxt [STAGES];
  logic [SLICE-1:0] w_sum [STAGES];
  logic             w_cout[STAGES];

  logic             r_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;
  logic             w_adv;

  assign w_adv   = ~r_valid | ready_i;
  assign ready_o = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic w_cin;
    if (k == 0) begin : g_first
      assign w_cin = 1'b1;
    end else begin : g_rest
      assign w_cin = r_stg[k].carry;
    end

    csel_slice #(.SLICE(SLICE)) u_slice (
      .i_a   (r_stg[k].a[slice_lo(k, SLICE) +: SLICE]),
      .i_b   (r_stg[k].b[slice_lo(k, SLICE) +: SLICE]),
      .i_sel (w_cin),
      .o_sum (w_sum[k]),
      .o_cout(w_cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt[k]                                   = r_stg[k];
      w_nxt[k].res[slice_lo(k, SLICE) +: SLICE] = w_sum[k];
      w_nxt[k].carry                             = w_cout[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stg[k] <= '0;
      end
      r_valid  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_adv) begin
      r_stg[0] <= '{valid:  valid_i,
                    res:    '0,
                    a:      num1_i,
                    b:      ~num2_i,
                    carry:  1'b1,
                    sign_a: num1_i[WIDTH-1],
                    sign_b: num2_i[WIDTH-1]};
      for (int k = 1; k < STAGES; k++) begin
        r_stg[k] <= w_nxt[k-1];
      end
      r_valid <= r_stg[STAGES-1].valid;
      // Bubbles leave the result registers untouched.
      if (r_stg[STAGES-1].valid) begin
        r_diff   <= w_nxt[STAGES-1].res;
        r_borrow <= ~w_nxt[STAGES-1].carry;
        r_ovf    <= (r_stg[STAGES-1].sign_a ^ r_stg[STAGES-1].sign_b) &
                    (w_nxt[STAGES-1].res[WIDTH-1] ^ r_stg[STAGES-1].sign_a);
      end
    end
  end

  assign valid_o    = r_valid;
  assign diff_o     = r_diff;
  assign borrow_o   = r_borrow;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_yontem4_pipelined_subtractor.sv
// tb/tb_yontem4_pipelined_subtractor.sv - self-checking bench for the pipelined subtractor
module tb_yontem4_pipelined_subtractor;

  logic        clk_i;
  logic        rst_i;
  logic [63:0] num1_i;
  logic [63:0] num2_i;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] diff_o;
  logic        borrow_o;
  logic        overflow_o;
  logic        valid_o;
  logic        ready_i;

  yontem4_pipelined_subtractor dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .num1_i    (num1_i),
    .num2_i    (num2_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .diff_o    (diff_o),
    .borrow_o  (borrow_o),
    .overflow_o(overflow_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  typedef struct packed {
    logic [63:0] n1;
    logic [63:0] n2;
    logic [63:0] diff;
    logic        borrow;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [63:0] diff;
    logic        borrow;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b);
    res_t        r;
    logic [64:0] sd;
    r.diff   = a - b;
    r.borrow = (a < b);
    sd       = {a[63], a} - {b[63], b};
    r.ovf    = sd[64] ^ sd[63];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: transfers are judged at the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk_i) begin
    check("ready_rule", {63'd0, ready_o}, {63'd0, (!valid_o || ready_i)});
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("stale_result", 64'd1, 64'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("mon_diff", diff_o, e.diff);
          check("mon_borrow", {63'd0, borrow_o}, {63'd0, e.borrow});
          check("mon_ovf", {63'd0, overflow_o}, {63'd0, e.ovf});
        end
      end
      if (valid_i && ready_o) exp_q.push_back(model(num1_i, num2_i));
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    ready_i = 1'b1;
    valid_i = 1'b1;
    num1_i  = v.n1;
    num2_i  = v.n2;
    tick();
    valid_i = 1'b0;
    lat     = 0;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    check("vec_diff", diff_o, v.diff);
    check("vec_borrow", {63'd0, borrow_o}, {63'd0, v.borrow});
    check("vec_ovf", {63'd0, overflow_o}, {63'd0, v.ovf});
    tick();
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b);
    bit acc;
    valid_i = 1'b1;
    num1_i  = a;
    num2_i  = b;
    acc     = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
    end
    if (!acc) check("send_timeout", 64'd1, 64'd0);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    valid_i = 1'b0;
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) tick();
    tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   n;

    vecs[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[2] = '{64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b0};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[7] = '{64'h0000_0001_0000_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_FFFF_0000, 1'b0, 1'b0};

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    num1_i  = '0;
    num2_i  = '0;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_diff", diff_o, 64'd0);
    check("rst_borrow", {63'd0, borrow_o}, 64'd0);
    check("rst_ovf", {63'd0, overflow_o}, 64'd0);
    check("rst_ready", {63'd0, ready_o}, 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back sweep with a 3-cycle output stall once the pipe is full.
    ready_i = 1'b1;
    n = 0;
    for (int ia = 0; ia < 12; ia++) begin
      for (int jb = 0; jb < 10; jb++) begin
        if (n == 20) begin
          ready_i = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            check("stall_ready", {63'd0, ready_o}, 64'd0);
            check("stall_valid", {63'd0, valid_o}, 64'd1);
            check("stall_diff", diff_o, exp_q[0].diff);
            @(posedge clk_i);
            #1;
          end
          ready_i = 1'b1;
        end
        send(64'(ia * 59 * 1409), 64'(jb * 73 * 1361));
        n++;
      end
    end
    drain();

    // Reset with three results in flight.
    send(64'd100, 64'd1);
    send(64'd200, 64'd2);
    send(64'd300, 64'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_valid", {63'd0, valid_o}, 64'd0);
    check("midrst_diff", diff_o, 64'd0);
    for (int t = 0; t < 6; t++) begin
      check("midrst_quiet", {63'd0, valid_o}, 64'd0);
      tick();
    end
    run_vec('{64'd10, 64'd4, 64'd6, 1'b0, 1'b0});

    // Random operands with random valid and backpressure.
    for (int t = 0; t < 400; t++) begin
      valid_i = ($urandom_range(3) != 0);
      ready_i = ($urandom_range(9) < 7);
      case ($urandom_range(7))
        0:       num1_i = num2_i;
        1:       num1_i = 64'd0;
        default: num1_i = {$urandom, $urandom};
      endcase
      if ($urandom_range(7) == 0) num2_i = 64'hFFFF_FFFF_FFFF_FFFF;
      else                        num2_i = {$urandom, $urandom};
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yontem4_pipelined_subtractor.md
Name: yontem4_pipelined_subtractor

Overview:
- Pipelined 64-bit carry-select subtractor. Computes num1_i − num2_i as num1_i + ~num2_i + 1.
- Built from 16-bit carry-select slices, one slice resolved per pipeline stage. The borrow chain is registered between stages.
- Companion inverse operation to the combinational carry-select adder. Same operand port naming, so the existing exhaustive-style benches can drive either block.
- Adds a valid/ready handshake so it can sit in a streaming datapath.

Parameters:
- WIDTH, 64, operand and result width; must be a multiple of SLICE.
- SLICE, 16, carry-select slice width; one slice per stage.
- STAGES, WIDTH/SLICE (4), pipeline depth (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- num1_i  in  WIDTH  minuend.
- num2_i  in  WIDTH  subtrahend.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block accepts operands this cycle.
- diff_o  out  WIDTH  num1 − num2, modulo 2^WIDTH.
- borrow_o  out  1  1 when num1 < num2 (unsigned).
- overflow_o  out  1  signed overflow of the subtraction.
- valid_o  out  1  diff_o/borrow_o/overflow_o valid.
- ready_i  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All stage valid bits clear; valid_o=0; diff_o=0; borrow_o=0; overflow_o=0.
  - All skew and carry registers clear.
  - Reset overrides any handshake in the same cycle.
- Advance enable: adv = ~valid_o | ready_i. ready_o = adv, combinational.
  - When adv=0, every stage register holds (global stall). No bubble squeezing.
- Transfer:
  - An input transfer occurs when valid_i & ready_o. Stage-0 valid loads valid_i when adv=1, so bubbles propagate.
  - An output transfer occurs when valid_o & ready_i.
- Latency and throughput:
  - Fixed STAGES=4 cycles from input transfer to valid_o, absent stalls.
  - Throughput of 1 result per cycle.
- Stage k (0..3):
  - Takes slice k of num1 and of ~num2, carried in skewed operand registers.
  - Forms two candidate sums: carry-in 0 and carry-in 1.
  - Selects one using the carry registered by stage k−1. Stage 0 carry-in is constant 1.
  - Registers the selected 16-bit result, the carry-out, and the remaining unprocessed slices.
  - Completed lower slices travel alongside the data.
- Output:
  - diff_o is the assembled 64-bit result.
  - borrow_o = ~carry-out of the top slice.
  - overflow_o = (num1[63] ≠ num2[63]) & (diff[63] ≠ num1[63]); the operand sign bits are carried through the pipeline.
- Output stability: outputs hold their values while valid_o=1 & ready_i=0. When valid_o=0, outputs hold their last values (no requirement beyond reset).
- Boundary cases:
  - Equal operands → diff 0, borrow 0.
  - 0 − 1 → all ones, borrow 1.
  - A carry crossing all slice boundaries, e.g. 2^48 − 1, must resolve correctly through registered carries.
  - Simultaneous input and output transfer while full is allowed and keeps 4 results in flight.
- Reset mid-operation: in-flight results are discarded and never appear on valid_o. The first transfer after reset release behaves exactly as from power-up.

Decomposition:
- Shared package yontem_pkg holds:
  - WIDTH_C=64, SLICE_C=16, STAGES_C=4.
  - The slice-index helper function.
  - A stage payload struct: partial result, skewed operand slices, carry, sign bits, valid.
- One sub-module: csel_slice.
  - Combinational; SLICE-wide.
  - Inputs a, b, carry-in select.
  - Outputs selected sum and carry-out, computed as dual ripple sums followed by a mux.
  - Instantiated STAGES times inside yontem4_pipelined_subtractor.

Test Plan:
1. Basic: reset 2 cycles, then send num1=5, num2=3, ready_i=1 → after 4 cycles valid_o=1, diff_o=2, borrow_o=0, overflow_o=0.
2. Negative result: num1=3, num2=5 → diff_o=0xFFFF_FFFF_FFFF_FFFE, borrow_o=1, overflow_o=0.
3. Cross-slice borrow: num1=0x0001_0000_0000_0000, num2=1 → diff_o=0x0000_FFFF_FFFF_FFFF, borrow_o=0. Also 0 − 1 → 0xFFFF_FFFF_FFFF_FFFF, borrow_o=1.
4. Signed overflow: num1=0x8000_0000_0000_0000, num2=1 → diff_o=0x7FFF_FFFF_FFFF_FFFF, overflow_o=1, borrow_o=0.
5. Streaming and backpressure:
   - Drive the i/j sweep (i*=59, j*=73, both < 1000000) back-to-back.
   - Hold ready_i=0 for 3 cycles mid-stream → ready_o=0 during the stall, diff_o stable, no loss or duplication.
   - Results arrive in order, each equal to (i−j) mod 2^64; error count 0.
6. Reset mid-flight: 3 operands in flight, assert rst_i 1 cycle → valid_o=0 next cycle and no stale result emerges. A new input 10−4 yields diff_o=6 exactly 4 cycles after acceptance.
